// File: rtl/tetris_pkg.sv
// Shared Tetris playfield constants, row type and line-clear FSM state encoding.
package tetris_pkg;

    localparam int COLS    = 10;
    localparam int ROWS    = 20;
    localparam int BOARD_W = COLS * ROWS;

    typedef logic [COLS-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/row_collapse.sv
// Combinational single-row eliminator: flags whether the indexed row is full and
// produces the board with that row removed and everything above shifted down one.
module row_collapse #(
    parameter int COLS  = 10,
    parameter int ROWS  = 20,
    parameter int IDX_W = 5
) (
    input  logic [0:COLS*ROWS-1] board,
    input  logic [IDX_W-1:0]     row_idx,
    output logic                 row_full,
    output logic [0:COLS*ROWS-1] collapsed
);

    logic [COLS-1:0] cur_row_s;

    // Full-row detect on the indexed row and shift-down of every row at or above it
    always_comb begin
        cur_row_s = board[int'(row_idx)*COLS +: COLS];
        row_full  = &cur_row_s;
        collapsed = board;
        for (int r = 0; r < ROWS; r++) begin
            if (r < int'(row_idx)) begin
                collapsed[r*COLS +: COLS] = board[r*COLS +: COLS];
            end else if (r < ROWS - 1) begin
                collapsed[r*COLS +: COLS] = board[(r+1)*COLS +: COLS];
            end else begin
                collapsed[r*COLS +: COLS] = {COLS{1'b0}};
            end
        end
    end

endmodule

// File: rtl/line_clear_sequencer.sv
// Sequential row-elimination engine: scans the locked board bottom-up and removes
// one full row per cycle, then reports the collapsed board and cleared-line count.
module line_clear_sequencer #(
    parameter int COLS  = 10,
    parameter int ROWS  = 20,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [0:COLS*ROWS-1] board_in,
    output logic                 busy,
    output logic                 done,
    output logic [0:COLS*ROWS-1] board_out,
    output logic [CNT_W-1:0]     lines
);

    import tetris_pkg::*;

    localparam int BOARD_BITS = COLS * ROWS;
    localparam int IDX_W      = $clog2(ROWS);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    state_t                  state_r;
    logic [0:BOARD_BITS-1]   board_r;
    logic [0:BOARD_BITS-1]   collapsed_s;
    logic [IDX_W-1:0]        row_idx_r;
    logic [CNT_W-1:0]        lines_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    row_full_s;

    row_collapse #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .IDX_W (IDX_W)
    ) u_row_collapse (
        .board     (board_r),
        .row_idx   (row_idx_r),
        .row_full  (row_full_s),
        .collapsed (collapsed_s)
    );

    // Line-clear FSM; owns the working board, row index, line count and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            board_r   <= {BOARD_BITS{1'b0}};
            row_idx_r <= {IDX_W{1'b0}};
            lines_r   <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        board_r   <= board_in;
                        row_idx_r <= {IDX_W{1'b0}};
                        lines_r   <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= SCAN;
                    end
                end
                SCAN: begin
                    // A collapsed row leaves row_idx in place so the row shifted in is re-checked
                    if (row_full_s) begin
                        board_r <= collapsed_s;
                        lines_r <= lines_r + CNT_W'(1);
                    end else if (row_idx_r == LAST_ROW) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        row_idx_r <= row_idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign board_out = board_r;
    assign lines     = lines_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Self-checking bench for line_clear_sequencer: vector table with an expectation
// queue, plus hand-written reset, ignored-start and mid-scan-reset sequences.
module tb_line_clear_sequencer;

    typedef logic [0:199] board_t;

    typedef struct {
        board_t     din;
        board_t     exp_board;
        logic [4:0] exp_lines;
        int         exp_cycle;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    board_t     board_in;
    logic       busy;
    logic       done;
    board_t     board_out;
    logic [4:0] lines;

    int   n_vec;
    int   n_miss;
    vec_t exp_q[$];
    vec_t vecs[8];

    line_clear_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .board_in  (board_in),
        .busy      (busy),
        .done      (done),
        .board_out (board_out),
        .lines     (lines)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic board_t set_row(input board_t b, input int r);
        board_t t = b;
        for (int i = 0; i < 10; i++) t[r*10 + i] = 1'b1;
        return t;
    endfunction

    // One operation: start on edge 0, find done, compare against the queued expectation
    task automatic run_op(input vec_t v, input bit pulses);
        bit     got;
        vec_t   e;
        board_t ones;
        ones = '1;
        exp_q.push_back(v);
        @(negedge clk);
        board_in = v.din;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got   = 1'b0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                got = 1'b1;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", c);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", 200'(c), 200'(e.exp_cycle));
                    check("lines", 200'(lines), 200'(e.exp_lines));
                    check("board_out", board_out, e.exp_board);
                    check("busy_at_done", 200'(busy), 200'(1));
                end
                if (pulses) begin
                    board_in = ones;
                    start    = 1'b1;
                end
            end else if (pulses && c == 3) begin
                board_in = ones;
                start    = 1'b1;
            end
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_timeout: got no done in 60 cycles expected cycle %0d", v.exp_cycle);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done", 200'(busy), 200'(0));
        check("done_width", 200'(done), 200'(0));
        if (pulses) begin
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (done || busy) break;
            end
            check("ignored_start_busy", 200'(busy), 200'(0));
            check("ignored_start_done", 200'(done), 200'(0));
            check("ignored_start_lines", 200'(lines), 200'(v.exp_lines));
            check("ignored_start_board", board_out, v.exp_board);
        end
    endtask

    initial begin
        board_t b;
        board_t rnd;
        n_vec    = 0;
        n_miss   = 0;
        rst_n    = 1'b0;
        start    = 1'b1;
        for (int i = 0; i < 200; i++) rnd[i] = 1'($urandom_range(0, 1));
        board_in = rnd;

        // Vector table
        vecs[0] = '{din: '0, exp_board: '0, exp_lines: 5'd0, exp_cycle: 21};
        b = set_row('0, 0); b[10] = 1'b1;
        vecs[1].din = b; vecs[1].exp_board = '0; vecs[1].exp_board[0] = 1'b1;
        vecs[1].exp_lines = 5'd1; vecs[1].exp_cycle = 22;
        b = '0; for (int r = 0; r < 4; r++) b = set_row(b, r); b[40] = 1'b1;
        vecs[2].din = b; vecs[2].exp_board = '0; vecs[2].exp_board[0] = 1'b1;
        vecs[2].exp_lines = 5'd4; vecs[2].exp_cycle = 25;
        b = set_row(set_row(set_row('0, 2), 5), 19); b[30] = 1'b1;
        vecs[3].din = b; vecs[3].exp_board = '0; vecs[3].exp_board[20] = 1'b1;
        vecs[3].exp_lines = 5'd3; vecs[3].exp_cycle = 24;
        vecs[4] = '{din: '1, exp_board: '0, exp_lines: 5'd20, exp_cycle: 41};
        b = set_row('0, 19); b[180] = 1'b1;
        vecs[5].din = b; vecs[5].exp_board = '0; vecs[5].exp_board[180] = 1'b1;
        vecs[5].exp_lines = 5'd1; vecs[5].exp_cycle = 22;
        b = '1; for (int r = 0; r < 20; r++) b[r*10 + (r % 10)] = 1'b0;
        vecs[6] = '{din: b, exp_board: b, exp_lines: 5'd0, exp_cycle: 21};
        b = set_row('0, 19);
        vecs[7] = '{din: b, exp_board: '0, exp_lines: 5'd1, exp_cycle: 22};

        // Reset held with start and a random board
        repeat (3) @(negedge clk);
        check("rst_busy", 200'(busy), 200'(0));
        check("rst_done", 200'(done), 200'(0));
        check("rst_lines", 200'(lines), 200'(0));
        check("rst_board", board_out, '0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("idle_busy", 200'(busy), 200'(0));
            check("idle_board", board_out, '0);
        end

        for (int i = 0; i < 8; i++) run_op(vecs[i], 1'b0);

        // Starts during SCAN and on the DONE cycle must be dropped
        run_op(vecs[2], 1'b1);

        // Asynchronous reset in the middle of a four-line clear
        @(negedge clk);
        board_in = vecs[2].din;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_lines_before", 200'(lines), 200'(4));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 200'(busy), 200'(0));
        check("mid_rst_board", board_out, '0);
        check("mid_rst_lines", 200'(lines), 200'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || busy) break;
        end
        check("mid_rst_no_done", 200'(done), 200'(0));
        check("mid_rst_idle", 200'(busy), 200'(0));

        run_op(vecs[3], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/line_clear_sequencer.md
# line_clear_sequencer

Sequential row-elimination engine for the 10x20 Tetris playfield. It sits between piece locking (the combined static board) and the static-board register. It replaces the unrolled chain of four combinational row eliminators with a small FSM that scans rows bottom-up and collapses each full row one per cycle. When finished it reports the collapsed board and the number of cleared lines, which drive score and display updates.

## Interface
Parameters:
- COLS, 10, columns per row
- ROWS, 20, rows on the board
- CNT_W, 5, width of the cleared-line counter; must hold ROWS

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request to process `board_in`; sampled only in IDLE
- board_in  in  [0:COLS*ROWS-1]  board after piece lock; captured on the accepted start
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse; `board_out` and `lines` are final
- board_out  out  [0:COLS*ROWS-1]  working/result board register
- lines  out  [CNT_W-1:0]  rows cleared by the last operation; held until the next accepted start

## Operation
- Board layout: row r occupies bits r*COLS .. r*COLS+COLS-1. Row 0 is the bottom row and row ROWS-1 is the top row. Bit = 1 means the cell is occupied.
- A row is full when all COLS bits are 1.
- FSM states:
  - IDLE: on start=1, board_reg <= board_in, row_idx <= 0, lines <= 0, go to SCAN. Otherwise hold everything.
  - SCAN (one row decision per cycle), evaluated on row row_idx:
    - Row full: rows row_idx..ROWS-2 <= rows row_idx+1..ROWS-1, top row <= 0, lines <= lines+1, row_idx unchanged so the same index is re-checked.
    - Row not full, row_idx < ROWS-1: row_idx <= row_idx+1.
    - Row not full, row_idx == ROWS-1: go to DONE.
  - DONE: done=1 for exactly this cycle; next state is IDLE.
- Rows below row_idx are never modified during SCAN.
- A full top row collapses into an empty row, is re-checked, and then the FSM ends normally.
- Outputs: board_out = board_reg at all times. lines is a register. busy = (state != IDLE).
- start while busy (including the DONE cycle) is ignored; it is neither queued nor counted.
- Arithmetic: lines never exceeds ROWS, so no saturation is needed. row_idx is 5 bits and counts 0..ROWS-1 with no wrap.
- Reset (async, rst_n=0), at any time including mid-SCAN:
  - state = IDLE, board_reg = 0, row_idx = 0, lines = 0, busy = 0, done = 0.
  - The interrupted operation is discarded.

## Timing
- Let the accepting edge (start=1 in IDLE) be edge 0, and let k be the number of full rows.
- SCAN occupies cycles 1..ROWS+k; DONE is cycle ROWS+k+1.
- done is therefore high at cycle ROWS+k+1: 21 for an empty board, 25 for four lines.
- busy rises in cycle 1 and falls in the cycle after done.
- The earliest next start is accepted on the edge ending the DONE cycle's successor, i.e. the first IDLE cycle.
- board_out reflects intermediate collapses during SCAN. Consumers sample it only on done, or while idle.
- Worst case is 2*ROWS+1 cycles with every row full. This fits inside one 500 kHz logic tick at the system clock.

## Structure
- Shared package tetris_pkg holds:
  - the COLS/ROWS/BOARD_W constants;
  - a `row_t` typedef of COLS bits;
  - the FSM state enum {IDLE, SCAN, DONE}.
- One natural sub-module: `row_collapse`, purely combinational. Inputs are board and row index; outputs are the row-full flag and the collapsed board. The FSM in line_clear_sequencer owns all registers.

## Test plan
- Reset: hold rst_n=0 with random board_in and start=1 → busy=0, done=0, lines=0, board_out=0. Deassert and idle 5 cycles → no change.
- Empty board, start → done at cycle 21, lines=0, board_out=0, busy low at cycle 22.
- Row 0 full plus bit 10 set, start → done at cycle 22, lines=1, board_out has only bit 0 set.
- Rows 0–3 full plus row 4 = bit 40 only, start → done at cycle 25, lines=4, board_out has only bit 0 set.
- Rows 2, 5 and 19 full plus bit 30 set, start → lines=3, done at cycle 24. Bit 30 (row 3) must end at row 2, i.e. bit 20; all other bits are 0.
- Robustness:
  - Pulse start again at cycles 3 and at done → ignored; lines stays unchanged.
  - Drop rst_n at cycle 10 of a 4-line clear → asynchronous return to IDLE, board_out=0, lines=0, no done pulse.
